reg_bank_ctrl: RTL and testbench
================================

// Module: reg_bank_ctrl
// PURPOSE
//  Command sequencer that drives the 2-read/1-write register bank (the registerBank
//  clk/WE/inAddr/inData/addrA/addrB/outA/outB interface). Accepts WRITE/READ/MOVE/SWAP
//  commands over valid/ready, sequences the bank ports, and returns READ data over
//  valid/ready. Sits between the datapath control unit and the register bank.
// PARAMETERS
//  DATA_W  16  register width; must equal bank data width
//  ADDR_W  3   register address width (2**ADDR_W registers)
// PORTS
//  clk        in   1       rising-edge clock, shared with register bank
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       controller can accept a command
//  cmd_op     in   2       00 WRITE, 01 READ, 10 MOVE, 11 SWAP
//  cmd_dst    in   ADDR_W  destination register (WRITE/MOVE/SWAP)
//  cmd_src    in   ADDR_W  source register (READ/MOVE/SWAP)
//  cmd_data   in   DATA_W  write data (WRITE only)
//  rsp_valid  out  1       READ result available
//  rsp_ready  in   1       consumer takes result
//  rsp_data   out  DATA_W  READ result
//  busy       out  1       state != IDLE
//  WE         out  1       bank write enable
//  inAddr     out  ADDR_W  bank write address
//  inData     out  DATA_W  bank write data
//  addrA      out  ADDR_W  bank read address A (= latched src)
//  addrB      out  ADDR_W  bank read address B (= latched dst)
//  outA       in   DATA_W  bank read data A (combinational from addrA)
//  outB       in   DATA_W  bank read data B (combinational from addrB)
// BEHAVIOUR
//  - Reset (sync, at rising edge with rst=1): state=IDLE; latched op/src/dst/data=0;
//    tmp=0; rsp_data=0. Outputs after reset: cmd_ready=1, rsp_valid=0, busy=0, WE=0,
//    inAddr=0, inData=0, addrA=0, addrB=0. cmd_ready forced 0 while rst is high.
//  - States: IDLE, EXEC, SWAP2, RESP. All outputs decoded from registered state/latches.
//  - IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready at edge: latch op/src/dst/data -> EXEC.
//  - EXEC (1 cycle): addrA=src, addrB=dst.
//      WRITE: WE=1, inAddr=dst, inData=data -> IDLE (no response).
//      READ : WE=0; rsp_data<=outA -> RESP.
//      MOVE : WE=1, inAddr=dst, inData=outA -> IDLE.
//      SWAP : WE=1, inAddr=dst, inData=outA; tmp<=outB (old dst) -> SWAP2.
//  - SWAP2 (1 cycle): WE=1, inAddr=src, inData=tmp -> IDLE.
//  - RESP: rsp_valid=1, rsp_data stable until rsp_ready=1 at edge -> IDLE. No new command
//    accepted while in RESP.
//  - Latency: WRITE/MOVE committed at edge after accept (2-cycle throughput); READ
//    rsp_valid 1 cycle after accept; SWAP both writes done 2 edges after accept.
//  - WE is high only in EXEC (WRITE/MOVE/SWAP) and SWAP2; never in IDLE/RESP.
//  - src==dst: MOVE rewrites same value; SWAP writes same value twice; both legal.
//  - READ reflects bank contents at EXEC (all prior commands committed).
//  - Reset mid-operation (EXEC/SWAP2/RESP): abandon op at reset edge; a SWAP interrupted
//    after its first write leaves dst updated, src unchanged; pending rsp discarded.
//  - cmd_* ignored when cmd_ready=0; rsp_ready ignored outside RESP.
// TESTING
//  1 Reset then WRITE dst=2 data=16'h35A1; READ src=2 -> rsp_data=16'h35A1, WE high 1 cycle.
//  2 WRITE r1=16'h1234, r5=16'h65DF; SWAP src=1 dst=5 -> READ r1=16'h65DF, r5=16'h1234;
//    WE high exactly 2 consecutive cycles.
//  3 WRITE r4=16'h12CE; MOVE src=4 dst=6; READ r6 -> 16'h12CE, r4 unchanged 16'h12CE.
//  4 READ r2 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data stable, cmd_ready=0;
//    rsp_ready=1 -> IDLE next cycle, cmd_ready=1.
//  5 SWAP src=3 dst=3 (r3=16'hEFD3) -> r3 stays 16'hEFD3; MOVE 0->0 likewise.
//  6 Assert rst during SWAP2 -> next cycle WE=0, busy=0, cmd_ready=1 after rst drops,
//    rsp_valid=0.

Source files
------------

// File: rtl/reg_bank_ctrl_if.sv
// Command/response bus between the datapath control unit and reg_bank_ctrl.
//   cmd_valid/cmd_ready : command handshake, cmd_op/cmd_dst/cmd_src/cmd_data payload
//   rsp_valid/rsp_ready : READ result handshake, rsp_data payload
// master = command issuer / result consumer, slave = reg_bank_ctrl.
interface reg_bank_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/reg_bank_ctrl.sv
// Command sequencer for a 2-read/1-write register bank.
// Accepts WRITE/READ/MOVE/SWAP commands on the bus (slave modport), drives the
// bank ports and returns READ data on the response side of the bus.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   bus           : command/response handshake (reg_bank_ctrl_if.slave)
//   busy          : controller not idle
//   WE/inAddr/inData : bank write port
//   addrA/addrB   : bank read addresses (latched src / dst)
//   outA/outB     : bank read data, combinational from addrA/addrB
module reg_bank_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_ctrl_if.slave    bus,
  output logic              busy,
  output logic              WE,
  output logic [ADDR_W-1:0] inAddr,
  output logic [DATA_W-1:0] inData,
  output logic [ADDR_W-1:0] addrA,
  output logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] outA,
  input  logic [DATA_W-1:0] outB
);

  typedef enum logic [1:0] {IDLE, EXEC, SWAP2, RESP} state_t;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_MOVE, OP_SWAP} op_t;

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] tmp_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              we_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_WRITE;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      tmp_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= op_t'(bus.cmd_op);
            src_q  <= bus.cmd_src;
            dst_q  <= bus.cmd_dst;
            data_q <= bus.cmd_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_READ: begin
              rsp_data_q <= outA;
              state      <= RESP;
            end
            OP_SWAP: begin
              // old dst value is held here while dst is overwritten this cycle
              tmp_q <= outB;
              state <= SWAP2;
            end
            default: state <= IDLE;
          endcase
        end
        SWAP2: state <= IDLE;
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // WE is masked by rst so a reset edge landing in SWAP2 does not commit the
  // second write: an interrupted SWAP leaves only dst updated.
  always_comb begin
    we_raw = ((state == EXEC) && (op_q != OP_READ)) || (state == SWAP2);
    WE     = we_raw && !rst;
    inAddr = '0;
    inData = '0;
    if ((state == EXEC) && (op_q != OP_READ)) begin
      inAddr = dst_q;
      inData = (op_q == OP_WRITE) ? data_q : outA;
    end else if (state == SWAP2) begin
      inAddr = src_q;
      inData = tmp_q;
    end
  end

  assign addrA         = src_q;
  assign addrB         = dst_q;
  assign busy          = (state != IDLE);
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: behavioural register bank attached to
// the bank ports, abstract register-array reference model, response scoreboard.
module tb_reg_bank_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam logic [1:0] OPW = 2'd0, OPR = 2'd1, OPM = 2'd2, OPS = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy, WE;
  logic [ADDR_W-1:0] inAddr, addrA, addrB;
  logic [DATA_W-1:0] inData, outA, outB;

  reg_bank_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

  reg_bank_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bif), .busy(busy), .WE(WE),
    .inAddr(inAddr), .inData(inData), .addrA(addrA), .addrB(addrB),
    .outA(outA), .outB(outB)
  );

  always #5 clk = ~clk;

  // physical register bank seen by the DUT
  logic [DATA_W-1:0] bank [8];
  always @(posedge clk) if (WE) bank[inAddr] <= inData;
  assign outA = bank[addrA];
  assign outB = bank[addrB];

  // reference model and scoreboard
  logic [DATA_W-1:0] m [8];
  logic [DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int we_run   = 0;
  int last_run = 0;
  bit rand_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // response monitor and WE activity tracker
  always @(negedge clk) begin
    if (WE) begin
      we_cnt++;
      we_run++;
    end else if (we_run != 0) begin
      last_run = we_run;
      we_run   = 0;
    end
    if (!rst && bif.rsp_valid && bif.rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'(bif.rsp_valid), 32'd0);
      else check("rsp_data", 32'(bif.rsp_data), 32'(exp_q.pop_front()));
    end
  end

  // random backpressure during the random phase
  always @(posedge clk) if (rand_en) #1 bif.rsp_ready = ($urandom_range(0, 3) != 0);

  task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [15:0] data);
    logic [15:0] t;
    int unsigned k = 0;
    @(negedge clk);
    while (!bif.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bif.cmd_ready) begin
      check("cmd_accept", 32'(bif.cmd_ready), 32'd1);
      return;
    end
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_dst   = dst;
    bif.cmd_src   = src;
    bif.cmd_data  = data;
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    bif.cmd_data = $urandom;
    case (op)
      OPW: m[dst] = data;
      OPR: exp_q.push_back(m[src]);
      OPM: m[dst] = m[src];
      default: begin
        t      = m[dst];
        m[dst] = m[src];
        m[src] = t;
      end
    endcase
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (busy && k < 50);
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_dst = '0;
    bif.cmd_src = '0; bif.cmd_data = '0; bif.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bank[i] = '0;
      m[i]    = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_rst", 32'(bif.cmd_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bif.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(WE), 32'd0);
    check("rst_inaddr", 32'(inAddr), 32'd0);
    check("rst_indata", 32'(inData), 32'd0);
    check("rst_addra", 32'(addrA), 32'd0);
    check("rst_addrb", 32'(addrB), 32'd0);
    check("rst_rsp_data", 32'(bif.rsp_data), 32'd0);

    // 1: write then read back
    w0 = we_cnt;
    issue(OPW, 3'd2, 3'd0, 16'h35A1);
    wait_idle(); settle();
    check("t1_we_cycles", 32'(we_cnt - w0), 32'd1);
    issue(OPR, 3'd0, 3'd2, 16'h0);
    wait_idle();

    // 2: swap
    issue(OPW, 3'd1, 3'd0, 16'h1234);
    issue(OPW, 3'd5, 3'd0, 16'h65DF);
    wait_idle(); settle();
    w0 = we_cnt;
    issue(OPS, 3'd5, 3'd1, 16'h0);
    wait_idle(); settle();
    check("t2_we_cycles", 32'(we_cnt - w0), 32'd2);
    check("t2_we_run", 32'(last_run), 32'd2);
    issue(OPR, 3'd0, 3'd1, 16'h0);
    issue(OPR, 3'd0, 3'd5, 16'h0);

    // 3: move
    issue(OPW, 3'd4, 3'd0, 16'h12CE);
    issue(OPM, 3'd6, 3'd4, 16'h0);
    issue(OPR, 3'd0, 3'd6, 16'h0);
    issue(OPR, 3'd0, 3'd4, 16'h0);
    wait_idle();

    // 4: response backpressure
    bif.rsp_ready = 1'b0;
    issue(OPR, 3'd0, 3'd2, 16'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_rsp_valid", 32'(bif.rsp_valid), 32'd1);
      check("t4_rsp_stable", 32'(bif.rsp_data), 32'(m[2]));
      check("t4_ready_low", 32'(bif.cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1 bif.rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    check("t4_ready_back", 32'(bif.cmd_ready), 32'd1);
    check("t4_valid_drop", 32'(bif.rsp_valid), 32'd0);

    // 5: src == dst
    issue(OPW, 3'd3, 3'd0, 16'hEFD3);
    issue(OPW, 3'd0, 3'd0, 16'hA50F);
    issue(OPS, 3'd3, 3'd3, 16'h0);
    issue(OPM, 3'd0, 3'd0, 16'h0);
    issue(OPR, 3'd0, 3'd3, 16'h0);
    issue(OPR, 3'd0, 3'd0, 16'h0);
    wait_idle();

    // 6: reset during SWAP2
    issue(OPS, 3'd5, 3'd1, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_we_masked", 32'(WE), 32'd0);
    check("t6_ready_in_rst", 32'(bif.cmd_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    // only the first write (dst <= old src) landed, so src keeps its old value
    m[1] = m[5];
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_we", 32'(WE), 32'd0);
    check("t6_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("t6_ready", 32'(bif.cmd_ready), 32'd1);
    issue(OPR, 3'd0, 3'd1, 16'h0);
    issue(OPR, 3'd0, 3'd5, 16'h0);
    wait_idle();

    // random commands with random response backpressure
    rand_en = 1;
    for (int i = 0; i < 80; i++)
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom));
    for (int i = 0; i < 8; i++) issue(OPR, 3'd0, 3'(i), 16'h0);
    wait_idle();
    rand_en = 0;
    @(posedge clk);
    #2 bif.rsp_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    settle();
    check("rsp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
